priv_guard: RTL and testbench
=============================

Name: priv_guard

Overview:
- Hardware privilege monitor that sits beside CPUTop. It consumes the core's PC, jump, data-memory address and register-select signals.
- It produces the registered io_programMemoryOffset / io_dataMemoryOffset values that CPUTop consumes.
- It detects ring violations, latches fault info and raises a sticky halt request.
- It moves the ring-0/ring-3 policy out of the simulation bench and into synthesizable RTL.

Parameters:
- ADDR_W, 16: width of program/data addresses and offsets.
- SEL_W, 5: register-select width.
- RING0_LAST, 32767: last privileged program address; user offset = RING0_LAST+1.
- RING0_ENTRY, 0: only legal user-to-kernel jump target.
- RING0_MEM_LAST, 0: last privileged data address.
- RING0_REG_LAST, 0: last privileged register index.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_pc  in  ADDR_W  current program counter.
- io_jump  in  1  jump taken this cycle.
- io_jumpTarget  in  ADDR_W  jump destination.
- io_memValid  in  1  data-memory access this cycle.
- io_memAddr  in  ADDR_W  data-memory address.
- io_aSel, io_bSel  in  SEL_W  register read selects; always treated as live.
- io_writeEnable  in  1  register-file write.
- io_writeSel  in  SEL_W  write register index.
- io_syscall  in  1  r31 != 0 (syscall requested).
- io_programMemoryOffset  out  ADDR_W  program offset to CPUTop.
- io_dataMemoryOffset  out  ADDR_W  data offset to CPUTop.
- io_mode  out  2  FSM state encoding.
- io_fault  out  1  sticky fault / halt request.
- io_faultCode  out  3  cause.
- io_faultAddr  out  ADDR_W  offending address or zero-extended register index.
- io_faultPc  out  ADDR_W  PC at the violation.

Behaviour:
- FSM states: KERNEL=0, USER=1, SYSCALL=2, FAULT=3. Reset enters KERNEL; all outputs are 0.
- user = (io_pc > RING0_LAST), evaluated combinationally each cycle.
- KERNEL/SYSCALL: if user, go to USER next edge. No checks are performed in these states.
- USER (checks active only while user is true):
  - JUMP violation: io_jump && io_jumpTarget <= RING0_LAST && io_jumpTarget != RING0_ENTRY.
  - Legal entry: io_jump && io_jumpTarget == RING0_ENTRY. Go to SYSCALL if io_syscall, else KERNEL.
  - MEM violation: io_memValid && io_memAddr <= RING0_MEM_LAST.
  - REG_WR violation: io_writeEnable && io_writeSel <= RING0_REG_LAST.
  - REG_RD violation: io_aSel or io_bSel <= RING0_REG_LAST; aSel is checked first.
  - Priority when several occur in the same cycle: JUMP(1) > MEM(2) > REG_WR(3) > REG_RD(4). Code 0 = none.
  - Any violation: next edge go to FAULT and latch io_faultCode/io_faultAddr/io_faultPc from that cycle. A violation overrides a simultaneous legal-entry transition.
- FAULT:
  - Absorbing; io_fault=1 from the edge after the violation.
  - Fault registers are frozen; only reset leaves FAULT.
  - Offsets hold their last value.
- Offsets are registered, 1-cycle latency, recomputed every edge except in FAULT:
  - prog = (user && !io_syscall) ? RING0_LAST+1 : 0.
  - data = user ? RING0_LAST+1 : 0.
- Width rules:
  - RING0_LAST+1 is computed in ADDR_W bits. If RING0_LAST = 2^ADDR_W-1, it wraps to 0 and user is never true; this is legal and all checks stay inert.
  - Register indices are zero-extended to ADDR_W.
- Reset asserted mid-fault or mid-syscall: next edge returns to KERNEL, all fault fields 0, offsets 0.

Optional Feature:
- Macro PRIV_SYSCALL_COUNT_EN.
- Defined: adds output io_syscallCount (16 bits). It increments on every USER-to-SYSCALL transition, saturates at 0xFFFF, resets to 0 and is frozen in FAULT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package priv_pkg holds:
  - mode encodings (KERNEL/USER/SYSCALL/FAULT);
  - fault code constants (NONE=0, JUMP=1, MEM=2, REG_WR=3, REG_RD=4);
  - default ring-boundary constants.
- One natural sub-module, priv_violation_check: purely combinational, produces the prioritized fault code and address from the USER-state inputs. The top keeps the FSM, offset registers and fault latches.

Test Plan:
- Reset, then pc=0x0010 for 3 cycles -> mode=0, both offsets 0, fault=0.
- pc=0x8000, syscall=0 -> mode=1 next edge; prog offset=0x8000 and data offset=0x8000 one cycle later.
- USER, jump to 0x0000 with syscall=1 -> mode=2, fault=0; with PRIV_SYSCALL_COUNT_EN, io_syscallCount=1.
- USER, jump to 0x0004 -> fault=1, code=1, faultAddr=0x0004, faultPc=current pc, mode=3; later inputs change nothing.
- USER, same cycle memValid with addr 0x0000 and writeEnable with writeSel=0 -> code=2 (MEM wins), faultAddr=0x0000.
- In FAULT, assert reset one cycle -> mode=0, fault=0, code=0, offsets=0 on the next edge.

Source files
------------

// File: rtl/priv_pkg.sv
// Shared encodings and default ring boundaries for the privilege monitor.
// Pure declarations: no logic, no latency, no flow control.
// No backpressure: nothing here carries traffic.
package priv_pkg;

  typedef enum logic [1:0] {
    MODE_KERNEL  = 2'd0,
    MODE_USER    = 2'd1,
    MODE_SYSCALL = 2'd2,
    MODE_FAULT   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    FC_NONE   = 3'd0,
    FC_JUMP   = 3'd1,
    FC_MEM    = 3'd2,
    FC_REG_WR = 3'd3,
    FC_REG_RD = 3'd4
  } fault_code_e;

  localparam int unsigned DEF_ADDR_W         = 16;
  localparam int unsigned DEF_SEL_W          = 5;
  localparam int unsigned DEF_RING0_LAST     = 32767;
  localparam int unsigned DEF_RING0_ENTRY    = 0;
  localparam int unsigned DEF_RING0_MEM_LAST = 0;
  localparam int unsigned DEF_RING0_REG_LAST = 0;

endpackage

// File: rtl/priv_violation_check.sv
// Prioritised ring-violation decode of one cycle of user-mode core activity.
// Purely combinational, zero latency.
// No backpressure: observes the core, never stalls it.
module priv_violation_check
  import priv_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned SEL_W          = DEF_SEL_W,
  parameter int unsigned RING0_LAST     = DEF_RING0_LAST,
  parameter int unsigned RING0_ENTRY    = DEF_RING0_ENTRY,
  parameter int unsigned RING0_MEM_LAST = DEF_RING0_MEM_LAST,
  parameter int unsigned RING0_REG_LAST = DEF_RING0_REG_LAST
) (
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [SEL_W-1:0]  a_sel,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic              write_enable,
  input  logic [SEL_W-1:0]  write_sel,
  output fault_code_e       code,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] ENTRY = ADDR_W'(RING0_ENTRY);

  // Comparisons are done in 32 bits so a boundary at the top of the address space stays exact.
  always_comb begin
    code = FC_NONE;
    addr = '0;
    if (jump && 32'(jump_target) <= RING0_LAST && jump_target != ENTRY) begin
      code = FC_JUMP;
      addr = jump_target;
    end else if (mem_valid && 32'(mem_addr) <= RING0_MEM_LAST) begin
      code = FC_MEM;
      addr = mem_addr;
    end else if (write_enable && 32'(write_sel) <= RING0_REG_LAST) begin
      code = FC_REG_WR;
      addr = ADDR_W'(write_sel);
    end else if (32'(a_sel) <= RING0_REG_LAST) begin
      code = FC_REG_RD;
      addr = ADDR_W'(a_sel);
    end else if (32'(b_sel) <= RING0_REG_LAST) begin
      code = FC_REG_RD;
      addr = ADDR_W'(b_sel);
    end
  end

endmodule

// File: rtl/priv_guard.sv
// Ring-0/ring-3 monitor beside CPUTop: memory offsets, fault capture, sticky halt (PRIV_SYSCALL_COUNT_EN adds a syscall counter).
// Offsets, mode and fault fields are registered: 1-cycle latency from inputs.
// No backpressure: the core is never stalled; a fault only raises the sticky halt request.
module priv_guard
  import priv_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned SEL_W          = DEF_SEL_W,
  parameter int unsigned RING0_LAST     = DEF_RING0_LAST,
  parameter int unsigned RING0_ENTRY    = DEF_RING0_ENTRY,
  parameter int unsigned RING0_MEM_LAST = DEF_RING0_MEM_LAST,
  parameter int unsigned RING0_REG_LAST = DEF_RING0_REG_LAST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_pc,
  input  logic              io_jump,
  input  logic [ADDR_W-1:0] io_jumpTarget,
  input  logic              io_memValid,
  input  logic [ADDR_W-1:0] io_memAddr,
  input  logic [SEL_W-1:0]  io_aSel,
  input  logic [SEL_W-1:0]  io_bSel,
  input  logic              io_writeEnable,
  input  logic [SEL_W-1:0]  io_writeSel,
  input  logic              io_syscall,
  output logic [ADDR_W-1:0] io_programMemoryOffset,
  output logic [ADDR_W-1:0] io_dataMemoryOffset,
  output logic [1:0]        io_mode,
  output logic              io_fault,
  output logic [2:0]        io_faultCode,
  output logic [ADDR_W-1:0] io_faultAddr,
  output logic [ADDR_W-1:0] io_faultPc
`ifdef PRIV_SYSCALL_COUNT_EN
  ,
  output logic [15:0]       io_syscallCount
`endif
);

  // Wraps to zero when ring 0 spans the whole space; user is then never true.
  localparam logic [ADDR_W-1:0] USER_OFF = ADDR_W'(RING0_LAST + 32'd1);
  localparam logic [ADDR_W-1:0] ENTRY    = ADDR_W'(RING0_ENTRY);

  mode_e             mode_q;
  fault_code_e       code_q;
  fault_code_e       viol_code;
  logic [ADDR_W-1:0] viol_addr;
  logic [ADDR_W-1:0] prog_off_q, data_off_q, fault_addr_q, fault_pc_q;
  logic              fault_q;
  logic              user, checks_on, violation, legal_entry;

  priv_violation_check #(
    .ADDR_W        (ADDR_W),
    .SEL_W         (SEL_W),
    .RING0_LAST    (RING0_LAST),
    .RING0_ENTRY   (RING0_ENTRY),
    .RING0_MEM_LAST(RING0_MEM_LAST),
    .RING0_REG_LAST(RING0_REG_LAST)
  ) u_check (
    .jump        (io_jump),
    .jump_target (io_jumpTarget),
    .mem_valid   (io_memValid),
    .mem_addr    (io_memAddr),
    .a_sel       (io_aSel),
    .b_sel       (io_bSel),
    .write_enable(io_writeEnable),
    .write_sel   (io_writeSel),
    .code        (viol_code),
    .addr        (viol_addr)
  );

  assign user        = 32'(io_pc) > RING0_LAST;
  assign checks_on   = (mode_q == MODE_USER) && user;
  assign violation   = checks_on && (viol_code != FC_NONE);
  assign legal_entry = checks_on && !violation && io_jump && (io_jumpTarget == ENTRY);

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q       <= MODE_KERNEL;
      prog_off_q   <= '0;
      data_off_q   <= '0;
      fault_q      <= 1'b0;
      code_q       <= FC_NONE;
      fault_addr_q <= '0;
      fault_pc_q   <= '0;
    end else begin
      if (mode_q != MODE_FAULT) begin
        prog_off_q <= (user && !io_syscall) ? USER_OFF : '0;
        data_off_q <= user ? USER_OFF : '0;
      end
      case (mode_q)
        MODE_KERNEL, MODE_SYSCALL: begin
          if (user) mode_q <= MODE_USER;
        end
        MODE_USER: begin
          if (violation) begin
            mode_q       <= MODE_FAULT;
            fault_q      <= 1'b1;
            code_q       <= viol_code;
            fault_addr_q <= viol_addr;
            fault_pc_q   <= io_pc;
          end else if (legal_entry) begin
            mode_q <= io_syscall ? MODE_SYSCALL : MODE_KERNEL;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PRIV_SYSCALL_COUNT_EN
  logic [15:0] syscall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      syscall_cnt_q <= '0;
    end else if (legal_entry && io_syscall && syscall_cnt_q != 16'hFFFF) begin
      syscall_cnt_q <= syscall_cnt_q + 16'd1;
    end
  end

  assign io_syscallCount = syscall_cnt_q;
`endif

  assign io_programMemoryOffset = prog_off_q;
  assign io_dataMemoryOffset    = data_off_q;
  assign io_mode                = mode_q;
  assign io_fault               = fault_q;
  assign io_faultCode           = code_q;
  assign io_faultAddr           = fault_addr_q;
  assign io_faultPc             = fault_pc_q;

endmodule

// File: tb/tb_priv_guard.sv
// Directed-vector bench for priv_guard: table of per-cycle stimulus/expectations plus hand sequences.
// Outputs are sampled 1 time unit after each rising edge.
module tb_priv_guard;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] io_pc, io_jumpTarget, io_memAddr;
  logic        io_jump, io_memValid, io_writeEnable, io_syscall;
  logic [4:0]  io_aSel, io_bSel, io_writeSel;
  logic [15:0] io_programMemoryOffset, io_dataMemoryOffset, io_faultAddr, io_faultPc;
  logic [1:0]  io_mode;
  logic        io_fault;
  logic [2:0]  io_faultCode;
`ifdef PRIV_SYSCALL_COUNT_EN
  logic [15:0] io_syscallCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  priv_guard dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_pc                 (io_pc),
    .io_jump               (io_jump),
    .io_jumpTarget         (io_jumpTarget),
    .io_memValid           (io_memValid),
    .io_memAddr            (io_memAddr),
    .io_aSel               (io_aSel),
    .io_bSel               (io_bSel),
    .io_writeEnable        (io_writeEnable),
    .io_writeSel           (io_writeSel),
    .io_syscall            (io_syscall),
    .io_programMemoryOffset(io_programMemoryOffset),
    .io_dataMemoryOffset   (io_dataMemoryOffset),
    .io_mode               (io_mode),
    .io_fault              (io_fault),
    .io_faultCode          (io_faultCode),
    .io_faultAddr          (io_faultAddr),
    .io_faultPc            (io_faultPc)
`ifdef PRIV_SYSCALL_COUNT_EN
    ,
    .io_syscallCount       (io_syscallCount)
`endif
  );

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        jmp;
    logic [15:0] jt;
    logic        mv;
    logic [15:0] ma;
    logic [4:0]  a, b;
    logic        we;
    logic [4:0]  ws;
    logic        sc;
    logic [1:0]  e_mode;
    logic [15:0] e_prog, e_data;
    logic        e_fault;
    logic [2:0]  e_code;
    logic [15:0] e_fa, e_fpc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [15:0] pc, input logic jmp, input logic [15:0] jt,
                       input logic mv, input logic [15:0] ma, input logic [4:0] a, input logic [4:0] b,
                       input logic we, input logic [4:0] ws, input logic sc);
    reset = rst; io_pc = pc; io_jump = jmp; io_jumpTarget = jt; io_memValid = mv; io_memAddr = ma;
    io_aSel = a; io_bSel = b; io_writeEnable = we; io_writeSel = ws; io_syscall = sc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic [1:0] m, input logic [15:0] p, input logic [15:0] d,
                         input logic f, input logic [2:0] c, input logic [15:0] fa, input logic [15:0] fpc);
    chk("mode", idx, 32'(io_mode), 32'(m));
    chk("prog_off", idx, 32'(io_programMemoryOffset), 32'(p));
    chk("data_off", idx, 32'(io_dataMemoryOffset), 32'(d));
    chk("fault", idx, 32'(io_fault), 32'(f));
    chk("fault_code", idx, 32'(io_faultCode), 32'(c));
    chk("fault_addr", idx, 32'(io_faultAddr), 32'(fa));
    chk("fault_pc", idx, 32'(io_faultPc), 32'(fpc));
  endtask

  initial begin
    // rst pc jmp jt mv ma a b we ws sc | mode prog data fault code faddr fpc (values after the edge)
    vecs.push_back('{1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8001, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    // syscall flag alone clears only the program offset
    vecs.push_back('{0, 16'h8002, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 1, 1, 16'h0000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8003, 1, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 1, 2, 16'h0000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 2, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0100, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, 0, 0, 2, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h9000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h9004, 1, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'hA000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'hA001, 1, 16'h8000, 1, 16'h0001, 1, 2, 1, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'hA002, 1, 16'h0004, 0, 16'h0000, 1, 2, 0, 1, 0, 3, 16'h8000, 16'h8000, 1, 1, 16'h0004, 16'hA002});
    vecs.push_back('{0, 16'h0000, 1, 16'h0000, 1, 16'h0000, 0, 0, 1, 0, 1, 3, 16'h8000, 16'h8000, 1, 1, 16'h0004, 16'hA002});
    vecs.push_back('{1, 16'h9000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8010, 0, 16'h0000, 1, 16'h0000, 1, 2, 1, 0, 0, 3, 16'h8000, 16'h8000, 1, 2, 16'h0000, 16'h8010});
    vecs.push_back('{1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8020, 0, 16'h0000, 1, 16'h0001, 1, 2, 1, 0, 0, 3, 16'h8000, 16'h8000, 1, 3, 16'h0000, 16'h8020});
    vecs.push_back('{1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8030, 0, 16'h0000, 0, 16'h0000, 3, 0, 0, 1, 0, 3, 16'h8000, 16'h8000, 1, 4, 16'h0000, 16'h8030});
    vecs.push_back('{1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    // violation beats a simultaneous legal syscall entry
    vecs.push_back('{0, 16'h8040, 1, 16'h0000, 1, 16'h0000, 1, 2, 0, 1, 1, 3, 16'h0000, 16'h8000, 1, 2, 16'h0000, 16'h8040});
    vecs.push_back('{1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h0010, 0, 16'h0000, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8000, 0, 16'h0000, 0, 16'h0000, 0, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8001, 0, 16'h0000, 0, 16'h0000, 0, 2, 0, 1, 0, 3, 16'h8000, 16'h8000, 1, 4, 16'h0000, 16'h8001});
    vecs.push_back('{1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8000, 0, 16'h0000, 0, 16'h0000, 1, 2, 0, 1, 0, 1, 16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 16'h8050, 1, 16'h7FFF, 0, 16'h0000, 1, 2, 0, 1, 0, 3, 16'h8000, 16'h8000, 1, 1, 16'h7FFF, 16'h8050});

    drive(1, 16'h0, 0, 16'h0, 0, 16'h0, 1, 2, 0, 1, 0);
    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].jmp, vecs[i].jt, vecs[i].mv, vecs[i].ma,
            vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].ws, vecs[i].sc);
      tick();
      chk_all(i, vecs[i].e_mode, vecs[i].e_prog, vecs[i].e_data, vecs[i].e_fault,
              vecs[i].e_code, vecs[i].e_fa, vecs[i].e_fpc);
    end

    // Reset asserted while in SYSCALL returns everything to zero.
    drive(1, 16'h0000, 0, 16'h0, 0, 16'h0, 1, 2, 0, 1, 0); tick();
    drive(0, 16'h8000, 0, 16'h0, 0, 16'h0, 1, 2, 0, 1, 0); tick();
    drive(0, 16'h8001, 1, 16'h0, 0, 16'h0, 1, 2, 0, 1, 1); tick();
    chk_all(100, 2'd2, 16'h0000, 16'h8000, 1'b0, 3'd0, 16'h0, 16'h0);
`ifdef PRIV_SYSCALL_COUNT_EN
    chk("syscall_count", 100, 32'(io_syscallCount), 32'd1);
`endif
    drive(1, 16'h8002, 0, 16'h0, 0, 16'h0, 1, 2, 0, 1, 0); tick();
    chk_all(101, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0, 16'h0);
`ifdef PRIV_SYSCALL_COUNT_EN
    chk("syscall_count", 101, 32'(io_syscallCount), 32'd0);
`endif

    // Fault is absorbing: several cycles of arbitrary inputs leave every output frozen.
    drive(0, 16'h8000, 0, 16'h0, 0, 16'h0, 1, 2, 0, 1, 0); tick();
    drive(0, 16'hC123, 1, 16'h0004, 0, 16'h0, 1, 2, 0, 1, 0); tick();
    for (int k = 0; k < 6; k++) begin
      drive(0, 16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
            5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      tick();
      chk_all(200 + k, 2'd3, 16'h8000, 16'h8000, 1'b1, 3'd1, 16'h0004, 16'hC123);
    end
    drive(1, 16'h8000, 0, 16'h0, 0, 16'h0, 1, 2, 0, 1, 0); tick();
    chk_all(300, 2'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
